// File: rtl/attn_shift_pipe.sv
// Stepped power-of-two attenuator: a shift-amount FSM ramps one step per clock
// toward a selected target while a 2-stage pipeline scales samples by the captured shift.
module attn_shift_pipe #(
  parameter int WIDTH = 32,
  parameter int SHW   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic [2:0]       sel,
  input  logic             sel_load,
  input  logic             round_en,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [SHW-1:0]   cur_shift,
  output logic             busy,
  output logic             bad_sel
);

  typedef enum logic {IDLE, RAMP} state_t;

  localparam logic signed [WIDTH:0] ONE     = {{WIDTH{1'b0}}, 1'b1};
  localparam logic signed [WIDTH:0] SAT_MAX = {2'b00, {(WIDTH-1){1'b1}}};

  state_t           state_reg;
  logic [SHW-1:0]   target_reg;
  logic [SHW-1:0]   cur_shift_reg;
  logic             bad_sel_reg;

  logic             map_ok;
  logic [SHW-1:0]   map_shift;
  logic             load_ok;
  logic [SHW-1:0]   goal;
  logic [SHW-1:0]   step_shift;

  logic             s1_valid_reg;
  logic [WIDTH-1:0] s1_data_reg;
  logic             s1_round_reg;
  logic [SHW-1:0]   s1_shift_reg;
  logic             out_valid_reg;
  logic [WIDTH-1:0] out_data_reg;

  logic signed [WIDTH:0] ext;
  logic signed [WIDTH:0] bias;
  logic signed [WIDTH:0] biased;
  logic signed [WIDTH:0] shifted;
  logic [WIDTH-1:0]      scaled;

  always_comb begin
    map_ok    = 1'b1;
    map_shift = '0;
    case (sel)
      3'b000:  map_shift = SHW'(10);
      3'b001:  map_shift = SHW'(8);
      3'b010:  map_shift = SHW'(6);
      3'b100:  map_shift = SHW'(4);
      3'b101:  map_shift = SHW'(2);
      3'b111:  map_shift = '0;
      default: map_ok    = 1'b0;
    endcase
  end

  // A load during a ramp redirects the very same edge's step toward the new goal.
  assign load_ok    = sel_load & map_ok;
  assign goal       = load_ok ? map_shift : target_reg;
  assign step_shift = (goal > cur_shift_reg) ? cur_shift_reg + SHW'(1)
                                             : cur_shift_reg - SHW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      target_reg    <= '0;
      cur_shift_reg <= '0;
      bad_sel_reg   <= 1'b0;
    end else begin
      bad_sel_reg <= sel_load & ~map_ok;
      if (load_ok) target_reg <= map_shift;
      case (state_reg)
        IDLE: begin
          if (load_ok && (map_shift != cur_shift_reg)) state_reg <= RAMP;
        end
        RAMP: begin
          if (goal == cur_shift_reg) begin
            state_reg <= IDLE;
          end else begin
            cur_shift_reg <= step_shift;
            if (step_shift == goal) state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
      s1_data_reg  <= '0;
      s1_round_reg <= 1'b0;
      s1_shift_reg <= '0;
    end else begin
      s1_valid_reg <= in_valid;
      if (in_valid) begin
        s1_data_reg  <= in_data;
        s1_round_reg <= round_en;
        s1_shift_reg <= cur_shift_reg;
      end
    end
  end

  // One guard bit keeps the rounding bias from wrapping the most positive sample.
  always_comb begin
    ext     = {s1_data_reg[WIDTH-1], s1_data_reg};
    bias    = ONE << (s1_shift_reg - SHW'(1));
    biased  = (s1_round_reg && (s1_shift_reg != '0)) ? ext + bias : ext;
    shifted = biased >>> s1_shift_reg;
    scaled  = (shifted > SAT_MAX) ? SAT_MAX[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
    end else begin
      out_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) out_data_reg <= scaled;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign cur_shift = cur_shift_reg;
  assign busy      = (state_reg == RAMP);
  assign bad_sel   = bad_sel_reg;

endmodule
